// File: rtl/vga_logo_engine.sv
// vga_logo_engine: VGA timing generator with a 2x2 coloured-square logo.
// A clk divider produces pix_ce. Pixel counters drive registered, pixel-aligned
// sync/de/rgb outputs. The logo origin is loaded through a valid/ready port and
// only takes effect at a frame boundary, so a frame is never drawn half old and
// half new.
// Optional feature: define LOGO_BOUNCE_EN to make the logo bounce by one pixel
// per frame whenever no new origin is pending.
//
// cfg handshake: a transfer happens on a clk where cfg_valid and cfg_ready are
// both 1. cfg_ready is 1 while no origin is pending. It drops on the clk after a
// transfer and returns on the clk after the frame_end that applies the origin.
// cfg_x/cfg_y are ignored while cfg_ready is 0.
module vga_logo_engine #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int WIN_SIZE   = 49,
  parameter int WIN_GAP    = 31,
  parameter int ORIGIN_X   = 256,
  parameter int ORIGIN_Y   = 41,
  parameter int COLOR_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [9:0]            cfg_x,
  input  logic [9:0]            cfg_y,
  output logic                  pix_ce,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] r_out,
  output logic [COLOR_BITS-1:0] g_out,
  output logic [COLOR_BITS-1:0] b_out,
  output logic                  frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LOGO    = 2 * WIN_SIZE + WIN_GAP;
  localparam int X_MAX   = H_ACTIVE - LOGO;
  localparam int Y_MAX   = V_ACTIVE - LOGO;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MW      = (HW > VW) ? HW : VW;
  localparam int CW      = ((MW > 10) ? MW : 10) + 2;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic [9:0]    org_x;
  logic [9:0]    org_y;
  logic [9:0]    pend_x;
  logic [9:0]    pend_y;
  logic [9:0]    clamp_x;
  logic [9:0]    clamp_y;
  logic          xfer;

  // Next divider value; pix_ce is registered so it lines up with div_cnt.
  always_comb begin
    div_nxt = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
  end

  // Pixel clock enable divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_ce  <= (div_nxt == DW'(CLK_DIV - 1));
    end
  end

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_end = pix_ce & h_last & v_last;

  // Horizontal/vertical position counters, advancing once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Geometry is evaluated on a common wider width so origin+LOGO cannot wrap.
  logic [CW-1:0] hx, vy, ox_w, oy_w;
  logic in_x0, in_x1, in_y0, in_y1, active, hs_on, vs_on;

  assign hx     = CW'(h_cnt);
  assign vy     = CW'(v_cnt);
  assign ox_w   = CW'(org_x);
  assign oy_w   = CW'(org_y);
  assign in_x0  = (hx >= ox_w) && (hx < ox_w + CW'(WIN_SIZE));
  assign in_x1  = (hx >= ox_w + CW'(WIN_SIZE + WIN_GAP)) && (hx < ox_w + CW'(LOGO));
  assign in_y0  = (vy >= oy_w) && (vy < oy_w + CW'(WIN_SIZE));
  assign in_y1  = (vy >= oy_w + CW'(WIN_SIZE + WIN_GAP)) && (vy < oy_w + CW'(LOGO));
  assign active = (hx < CW'(H_ACTIVE)) && (vy < CW'(V_ACTIVE));
  assign hs_on  = (hx >= CW'(H_ACTIVE + H_FP)) && (hx < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on  = (vy >= CW'(V_ACTIVE + V_FP)) && (vy < CW'(V_ACTIVE + V_FP + V_SYNC));

  // Registered video outputs: one pixel behind the counters, all aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync <= 1'b1;
      v_sync <= 1'b1;
      de     <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else if (pix_ce) begin
      h_sync <= ~hs_on;
      v_sync <= ~vs_on;
      de     <= active;
      r_out  <= {COLOR_BITS{active & ((in_x0 & in_y0) | (in_x1 & in_y1))}};
      g_out  <= {COLOR_BITS{active & in_x1 & (in_y0 | in_y1)}};
      b_out  <= {COLOR_BITS{active & in_x0 & in_y1}};
    end
  end

  // Clamp requested origin so the whole logo stays inside the active area.
  always_comb begin
    clamp_x = (cfg_x > 10'(X_MAX)) ? 10'(X_MAX) : cfg_x;
    clamp_y = (cfg_y > 10'(Y_MAX)) ? 10'(Y_MAX) : cfg_y;
  end

  assign xfer = cfg_valid & cfg_ready;

`ifdef LOGO_BOUNCE_EN
  logic       dir_x, dir_y;
  logic       bdx_nxt, bdy_nxt;
  logic [9:0] bx_nxt, by_nxt;

  // Next bounce step: reverse at an edge, so the edge position lasts one frame.
  always_comb begin
    bdx_nxt = dir_x;
    bdy_nxt = dir_y;
    if (dir_x && org_x >= 10'(X_MAX)) bdx_nxt = 1'b0;
    else if (!dir_x && org_x == 10'd0) bdx_nxt = 1'b1;
    if (dir_y && org_y >= 10'(Y_MAX)) bdy_nxt = 1'b0;
    else if (!dir_y && org_y == 10'd0) bdy_nxt = 1'b1;
    bx_nxt = org_x;
    by_nxt = org_y;
    if (X_MAX > 0) bx_nxt = bdx_nxt ? org_x + 10'd1 : org_x - 10'd1;
    if (Y_MAX > 0) by_nxt = bdy_nxt ? org_y + 10'd1 : org_y - 10'd1;
  end
`endif

  // Origin, pending slot and cfg_ready; pending is applied only at frame_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      org_x     <= 10'(ORIGIN_X);
      org_y     <= 10'(ORIGIN_Y);
      pend_x    <= '0;
      pend_y    <= '0;
      cfg_ready <= 1'b1;
`ifdef LOGO_BOUNCE_EN
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
`endif
    end else begin
      if (frame_end && !cfg_ready) begin
        org_x     <= pend_x;
        org_y     <= pend_y;
        pend_x    <= '0;
        pend_y    <= '0;
        cfg_ready <= 1'b1;
`ifdef LOGO_BOUNCE_EN
        dir_x     <= 1'b1;
        dir_y     <= 1'b1;
      end else if (frame_end) begin
        org_x     <= bx_nxt;
        org_y     <= by_nxt;
        dir_x     <= bdx_nxt;
        dir_y     <= bdy_nxt;
`endif
      end
      // A transfer on the frame_end clk itself lands here and waits a frame.
      if (xfer) begin
        pend_x    <= clamp_x;
        pend_y    <= clamp_y;
        cfg_ready <= 1'b0;
      end
    end
  end

endmodule
